// File: rtl/crc5_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : crc5_check_pkg
//  Purpose  : Shared definitions for the CRC5 frame checker: FSM state
//             encoding, CRC5 register width and the default CRC preset.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package crc5_check_pkg;

  localparam int CRC5_W = 5;

  localparam logic [CRC5_W-1:0] CRC5_INIT_DEFAULT = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : crc5_check_pkg
`default_nettype wire

// File: rtl/crc5_next.sv
`default_nettype none
// ============================================================================
//  Module   : crc5_next
//  Purpose  : Combinational byte-wide CRC5 update, polynomial x^5+x^2+1.
//             Shared by the checker and any generator-side logic.
//  Ports    : c [4:0] in  - current CRC register
//             d [7:0] in  - data byte
//             n [4:0] out - CRC register after absorbing d
//  Revision : 1.0 - initial release
// ============================================================================
module crc5_next
  import crc5_check_pkg::*;
(
  input  logic [CRC5_W-1:0] c,
  input  logic [7:0]        d,
  output logic [CRC5_W-1:0] n
);

  always_comb begin
    n[0] = c[0] ^ c[2] ^ c[3] ^ d[0] ^ d[3] ^ d[5] ^ d[6];
    n[1] = c[1] ^ c[3] ^ c[4] ^ d[1] ^ d[4] ^ d[6] ^ d[7];
    n[2] = c[0] ^ c[3] ^ c[4] ^ d[0] ^ d[2] ^ d[3] ^ d[6] ^ d[7];
    n[3] = c[0] ^ c[1] ^ c[4] ^ d[1] ^ d[3] ^ d[4] ^ d[7];
    n[4] = c[1] ^ c[2] ^ d[2] ^ d[4] ^ d[5];
  end

endmodule : crc5_next
`default_nettype wire

// File: rtl/crc5_check.sv
`default_nettype none
// ============================================================================
//  Module   : crc5_check
//  Purpose  : Receives a byte frame (payload bytes, then a trailing CRC byte
//             flagged by last), runs CRC5 over the payload and reports a
//             pass/fail verdict with a one-cycle done pulse.
//  Config   : CRC5_CHECK_LEN_EN - when defined, counts payload bytes on len
//             (saturating at 255) and fails frames longer than MAX_LEN.
//             When undefined, len is tied to 0 and no length check is made.
//  Ports    : clk       in   clock, rising edge
//             rst       in   asynchronous active-high reset
//             enable    in   din holds a valid frame byte
//             din[7:0]  in   payload byte, or received CRC when last=1
//             last      in   marks the enabled byte as the CRC byte
//             busy      out  frame open or being checked
//             done      out  one-cycle verdict strobe
//             pass      out  CRC matched (held until next frame starts)
//             fail      out  CRC mismatch or malformed frame (held)
//             crc_calc  out  CRC computed over the payload (held)
//             len[7:0]  out  payload byte count
//  Revision : 1.0 - initial release
// ============================================================================
module crc5_check
  import crc5_check_pkg::*;
#(
  parameter logic [CRC5_W-1:0] CRC_INIT = CRC5_INIT_DEFAULT,
  parameter logic [7:0]        MAX_LEN  = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [7:0]        din,
  input  logic              last,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [CRC5_W-1:0] crc_calc,
  output logic [7:0]        len
);

  state_t              state_q, state_d;
  logic [CRC5_W-1:0]   crc_q, crc_d;
  logic [CRC5_W-1:0]   crc_calc_q, crc_calc_d;
  logic [CRC5_W-1:0]   crc_upd;
  logic [7:0]          rx_crc_q, rx_crc_d;
  logic                malformed_q, malformed_d;
  logic                match_q, match_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                len_over;

  // crc_q sits at CRC_INIT while idle, so it seeds the first byte too.
  crc5_next u_crc5_next (
    .c (crc_q),
    .d (din),
    .n (crc_upd)
  );

`ifdef CRC5_CHECK_LEN_EN
  logic [7:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if (enable && (state_q == ST_IDLE)) begin
      len_d = last ? 8'd0 : 8'd1;
    end else if (enable && !last && (state_q == ST_RECV) && (len_q != 8'hFF)) begin
      len_d = len_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) len_q <= 8'd0;
    else     len_q <= len_d;
  end

  assign len_over = (len_q > MAX_LEN);
  assign len      = len_q;
`else
  // No counter: the comparison folds to a constant 0.
  assign len_over = (8'd0 > MAX_LEN);
  assign len      = 8'd0;
`endif

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    rx_crc_d    = rx_crc_q;
    malformed_d = malformed_q;
    match_d     = match_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_d      = fail_q;
    crc_calc_d  = crc_calc_q;

    case (state_q)
      ST_IDLE: begin
        crc_d = CRC_INIT;
        if (enable) begin
          // Any accepted byte opens a new frame and retires the old verdict.
          pass_d = 1'b0;
          fail_d = 1'b0;
          if (last) begin
            rx_crc_d    = din;
            malformed_d = 1'b1;
            state_d     = ST_CHECK;
          end else begin
            crc_d       = crc_upd;
            malformed_d = 1'b0;
            state_d     = ST_RECV;
          end
        end
      end

      ST_RECV: begin
        if (enable) begin
          if (last) begin
            rx_crc_d = din;
            state_d  = ST_CHECK;
          end else begin
            crc_d = crc_upd;
          end
        end
      end

      ST_CHECK: begin
        match_d = (crc_q == rx_crc_q[CRC5_W-1:0]) && (rx_crc_q[7:CRC5_W] == 3'd0)
                  && !malformed_q && !len_over;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        done_d     = 1'b1;
        pass_d     = match_q;
        fail_d     = !match_q;
        crc_calc_d = crc_q;
        crc_d      = CRC_INIT;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      rx_crc_q    <= 8'd0;
      malformed_q <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      crc_calc_q  <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      rx_crc_q    <= rx_crc_d;
      malformed_q <= malformed_d;
      match_q     <= match_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      crc_calc_q  <= crc_calc_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign crc_calc = crc_calc_q;

endmodule : crc5_check
`default_nettype wire

// File: tb/tb_crc5_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc5_check
//  Purpose  : Directed self-checking bench for crc5_check. Expected CRC
//             values are hand-derived from the byte-wise update equations.
//             Honours CRC5_CHECK_LEN_EN (DUT built with MAX_LEN=2 then).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc5_check;

`ifdef CRC5_CHECK_LEN_EN
  localparam logic [7:0] TB_MAX_LEN = 8'd2;
`else
  localparam logic [7:0] TB_MAX_LEN = 8'd255;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] din;
  logic       last;
  logic       busy, done, pass, fail;
  logic [4:0] crc_calc;
  logic [7:0] len;

  int checks   = 0;
  int failures = 0;

  crc5_check #(
    .CRC_INIT (5'h1F),
    .MAX_LEN  (TB_MAX_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .din      (din),
    .last     (last),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .crc_calc (crc_calc),
    .len      (len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] elen(input int n);
`ifdef CRC5_CHECK_LEN_EN
    return n[7:0];
`else
    return (n == 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  // Called just after a negedge; the byte is sampled on the next posedge
  // and inputs are released on the following negedge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    enable = 1'b1;
    din    = d;
    last   = l;
    @(negedge clk);
    enable = 1'b0;
    last   = 1'b0;
    din    = 8'h00;
  endtask

  // Entered at the negedge right after the CRC byte was sampled (edge N).
  // The verdict must appear after edge N+2 and last exactly one cycle.
  task automatic verdict(input string tag, input logic exp_pass, input logic [4:0] exp_crc,
                         input logic [7:0] exp_len, input logic junk);
    chk({tag, "_busy_chk"}, busy, 1'b1);
    chk({tag, "_done_n0"}, done, 1'b0);
    if (junk) begin
      // Bytes offered while in CHECK and DONE must be dropped.
      enable = 1'b1;
      din    = 8'h00;
      last   = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done_n1"}, done, 1'b0);
    chk({tag, "_busy_done"}, busy, 1'b1);
    if (junk) begin
      din  = 8'h1F;
      last = 1'b1;
    end
    @(negedge clk);
    enable = 1'b0;
    last   = 1'b0;
    din    = 8'h00;
    chk({tag, "_done_n2"}, done, 1'b1);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_fail"}, fail, !exp_pass);
    chk({tag, "_crc_calc"}, crc_calc, exp_crc);
    chk({tag, "_len"}, len, exp_len);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_pass_hold"}, pass, exp_pass);
    chk({tag, "_excl"}, pass & fail, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    din    = 8'h00;
    last   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_crc", crc_calc, 5'h00);
    chk("rst_len", len, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // 0x00 from 0x1F -> 0x0F
    send_byte(8'h00, 1'b0);
    chk("t1_busy_open", busy, 1'b1);
    send_byte(8'h0F, 1'b1);
    verdict("t1", 1'b1, 5'h0F, elen(1), 1'b0);

    send_byte(8'h00, 1'b0);
    send_byte(8'h0E, 1'b1);
    verdict("t2", 1'b0, 5'h0F, elen(1), 1'b0);

    // Low bits match but bit 5 set
    send_byte(8'h00, 1'b0);
    send_byte(8'h2F, 1'b1);
    verdict("t3", 1'b0, 5'h0F, elen(1), 1'b0);

    // 0x00 then 0xFF with a 2-cycle gap -> 0x15
    send_byte(8'h00, 1'b0);
    repeat (2) @(negedge clk);
    chk("t4_gap_busy", busy, 1'b1);
    chk("t4_gap_done", done, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h15, 1'b1);
    verdict("t4", 1'b1, 5'h15, elen(2), 1'b0);

    // 0xFF alone from 0x1F -> 0x1B
    send_byte(8'hFF, 1'b0);
    send_byte(8'h1B, 1'b1);
    verdict("t5", 1'b1, 5'h1B, elen(1), 1'b0);

    // Empty frame is malformed even with a "matching" CRC byte; stray
    // bytes during CHECK/DONE must not open a frame.
    send_byte(8'h1F, 1'b1);
    verdict("t6", 1'b0, 5'h1F, elen(0), 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_idle_busy", busy, 1'b0);
    chk("t6_fail_held", fail, 1'b1);
    send_byte(8'h00, 1'b0);
    chk("t6_pass_clr", pass, 1'b0);
    chk("t6_fail_clr", fail, 1'b0);
    send_byte(8'h0F, 1'b1);
    verdict("t6b", 1'b1, 5'h0F, elen(1), 1'b0);

    // Reset in mid-frame
    send_byte(8'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk("t7_rst_busy", busy, 1'b0);
    chk("t7_rst_pass", pass, 1'b0);
    chk("t7_rst_crc", crc_calc, 5'h00);
    chk("t7_rst_len", len, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t7_no_done", done, 1'b0);
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h0F, 1'b1);
    verdict("t7b", 1'b1, 5'h0F, elen(1), 1'b0);

    // Three zero bytes: 0x1F -> 0x0F -> 0x01 -> 0x0D
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h0D, 1'b1);
`ifdef CRC5_CHECK_LEN_EN
    verdict("t8", 1'b0, 5'h0D, 8'd3, 1'b0);
`else
    verdict("t8", 1'b1, 5'h0D, 8'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_crc5_check
`default_nettype wire
